// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR pattern generator and checker: the default
// polynomial, the register length and the checker FSM encoding.
package lfsr_pkg;

    // Default register length and feedback mask (x^16+x^14+x^13+x^11+1).
    // The generator uses the same constants so both ends of the link match.
    localparam int          LFSR_WIDTH = 16;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    // Checker acquisition/tracking states.
    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

endpackage : lfsr_pkg

// File: rtl/lfsr_step.sv
// Combinational next-bit function of a Fibonacci LFSR: the predicted bit is
// the parity of the register contents masked by the tap set.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS
) (
    input  logic [WIDTH-1:0] state_i,
    output logic             bit_o
);

    assign bit_o = ^(state_i & TAPS);

endmodule : lfsr_step

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: seeds a local LFSR from the incoming stream,
// verifies it against its own predictions, then free-runs and counts errors.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS       = LFSR_TAPS,
    parameter int               LOCK_COUNT = 32,
    parameter int               WINDOW     = 64,
    parameter int               ERR_THRESH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       clr_err,
    output logic       locked,
    output logic       err_pulse,
    output logic       sync_loss,
    output logic [7:0] err_count,
    output logic [1:0] state_o
);

    localparam int SEED_W  = $clog2(WIDTH);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W   = $clog2(WINDOW);
    localparam int ERR_W   = $clog2(ERR_THRESH + 1);

    chk_state_e         fsm_q, fsm_d;
    logic [WIDTH-1:0]   lfsr_q, lfsr_d;
    logic [SEED_W-1:0]  seed_cnt_q, seed_cnt_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [WIN_W-1:0]   win_bit_q, win_bit_d;
    logic [ERR_W-1:0]   win_err_q, win_err_d;
    logic [7:0]         err_count_q, err_count_d;
    logic               err_pulse_q, err_pulse_d;
    logic               sync_loss_q, sync_loss_d;
    logic               locked_q;

    logic pred_bit;
    logic bit_err;
    logic lfsr_zero;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .state_i (lfsr_q),
        .bit_o   (pred_bit)
    );

    assign bit_err   = (bit_in != pred_bit);
    // An all-zero register predicts zeros forever, so it can never be trusted.
    assign lfsr_zero = (lfsr_q == '0);

    // Next-state logic: acquisition, verification and locked error tracking.
    always_comb begin
        fsm_d       = fsm_q;
        lfsr_d      = lfsr_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        win_bit_d   = win_bit_q;
        win_err_d   = win_err_q;
        err_count_d = err_count_q;
        err_pulse_d = 1'b0;
        sync_loss_d = 1'b0;

        if (bit_valid) begin
            case (fsm_q)
                SEED: begin
                    lfsr_d = {lfsr_q[WIDTH-2:0], bit_in};
                    if (seed_cnt_q == SEED_W'(WIDTH - 1)) begin
                        fsm_d       = VERIFY;
                        seed_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else begin
                        seed_cnt_d = seed_cnt_q + SEED_W'(1);
                    end
                end
                VERIFY: begin
                    lfsr_d = {lfsr_q[WIDTH-2:0], bit_in};
                    if (bit_err || lfsr_zero) begin
                        fsm_d       = SEED;
                        seed_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else if (match_cnt_q == MATCH_W'(LOCK_COUNT - 1)) begin
                        fsm_d       = LOCKED;
                        match_cnt_d = '0;
                        win_bit_d   = '0;
                        win_err_d   = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + MATCH_W'(1);
                    end
                end
                LOCKED: begin
                    // Shift the prediction so a corrupted bit never enters the register.
                    lfsr_d = {lfsr_q[WIDTH-2:0], pred_bit};
                    if (bit_err) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                    end
                    if (bit_err && (win_err_q == ERR_W'(ERR_THRESH - 1))) begin
                        fsm_d       = SEED;
                        sync_loss_d = 1'b1;
                        seed_cnt_d  = '0;
                        match_cnt_d = '0;
                        win_bit_d   = '0;
                        win_err_d   = '0;
                    end else if (win_bit_q == WIN_W'(WINDOW - 1)) begin
                        win_bit_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_bit_d = win_bit_q + WIN_W'(1);
                        win_err_d = win_err_q + ERR_W'(bit_err);
                    end
                end
                default: begin
                    fsm_d = SEED;
                end
            endcase
        end

        // Clearing takes priority over an error counted in the same cycle.
        if (clr_err) begin
            err_count_d = '0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= SEED;
            lfsr_q      <= '0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_bit_q   <= '0;
            win_err_q   <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
            sync_loss_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            lfsr_q      <= lfsr_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_bit_q   <= win_bit_d;
            win_err_q   <= win_err_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
            sync_loss_q <= sync_loss_d;
            locked_q    <= (fsm_d == LOCKED);
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign sync_loss = sync_loss_q;
    assign err_count = err_count_q;
    assign state_o   = fsm_q;

endmodule : lfsr_checker
